i2c_seq_ctrl: RTL and testbench
===============================

// Module: i2c_seq_ctrl
// PURPOSE
//  Parametrised I2C sensor sequencer (MPU-6050 class) between sensor logic and the byte-level i2c_driver.
//  Replays an N-entry register-write init table once, then polls a burst read of up to MAX_RD bytes every POLL_PERIOD clk.
//  Reads land atomically in a sample buffer.
//  Uses a tick enable instead of a derived clock; adds NACK/short-read error reporting and a restart path.
// PARAMETERS
//  CLK_DIV      6       clk cycles per tick pulse (driver bit-rate enable); >=2
//  N_INIT       3       init table entries (register writes); >=1
//  MAX_RD       14      max burst-read bytes held in sample buffer
//  POLL_PERIOD  12000   clk cycles from read done to next read request
//  SLAVE_ADDR   7'h68   7-bit device address driven on drv_slave
//  TIMEOUT_CYC  65535   clk cycles allowed per transaction (only with I2C_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1            system clock (12 MHz)
//  rst_n        in   1            async active-low reset
//  start        in   1            pulse: begin init+poll; accepted only in IDLE/ERR
//  init_addr    in   N_INIT*8     init register addresses, entry i at [i*8+:8]
//  init_data    in   N_INIT*8     init write data, entry i at [i*8+:8]
//  rd_reg       in   8            first register of burst read
//  rd_len       in   4            bytes per burst read
//  tick         out  1            1-clk pulse every CLK_DIV clk, to driver clock enable
//  drv_req      out  1            transaction request, held until drv_ack
//  drv_ack      in   1            driver accepted request (same-cycle handshake)
//  drv_rw       out  1            0 write, 1 read
//  drv_slave    out  7            = SLAVE_ADDR
//  drv_reg      out  8            register address
//  drv_wdata    out  8            write byte
//  drv_len      out  4            byte count (1 for writes)
//  drv_rvalid   in   1            one read byte valid on drv_rdata
//  drv_rdata    in   8            read byte
//  drv_done     in   1            1-clk pulse: transaction finished
//  drv_nack     in   1            qualifies drv_done: slave NACKed
//  sample       out  MAX_RD*8     last complete read, byte k at [k*8+:8]
//  sample_valid out  1            1-clk pulse when sample updated
//  init_done    out  1            sticky after last init write succeeds
//  busy         out  1            state != IDLE && state != ERR
//  error        out  1            sticky in ERR; cleared by accepted start
// BEHAVIOUR
//  Reset: all outputs 0, sample all 0, tick counter 0, state IDLE.
//  tick: free-running counter 0..CLK_DIV-1; pulse when counter==CLK_DIV-1; runs in every state.
//  States: IDLE, INIT_REQ, INIT_WAIT, RD_REQ, RD_WAIT, POLL_WAIT, ERR.
//  IDLE/ERR --start--> INIT_REQ, idx=0, error=0, init_done=0. start in any other state is ignored.
//  INIT_REQ: drv_req=1, rw=0, reg=init_addr[idx], wdata=init_data[idx], len=1.
//   Outputs stable while req high; on drv_ack -> INIT_WAIT with drv_req=0 next clk.
//  INIT_WAIT: on drv_done & !nack: if idx==N_INIT-1 then init_done=1 -> RD_REQ, else idx++ -> INIT_REQ.
//  RD_REQ: drv_req=1, rw=1, reg=rd_reg, len=eff_len; on drv_ack -> RD_WAIT, byte cnt=0.
//   eff_len = rd_len==0 ? 1 : min(rd_len, MAX_RD); latched at RD_REQ entry.
//  RD_WAIT: each drv_rvalid writes shadow[cnt], cnt++; bytes with cnt>=eff_len are dropped.
//   On drv_done & !nack & cnt>=eff_len: sample<=shadow (bytes >=eff_len keep old value), sample_valid pulse -> POLL_WAIT.
//  POLL_WAIT: counts POLL_PERIOD clk then -> RD_REQ; first read follows init immediately, no wait.
//  Errors -> ERR, error=1, drv_req=0, sample unchanged:
//   drv_done with drv_nack in any WAIT state; drv_done with cnt<eff_len in RD_WAIT.
//  drv_done and drv_rvalid in same clk: byte counted before the short-read check.
//  drv_done/drv_rvalid outside WAIT states ignored. Async reset mid-transaction drops drv_req immediately.
//  Latency: drv_req rises 1 clk after start; sample_valid 1 clk after final drv_done.
// CONFIGURATION
//  I2C_SEQ_TIMEOUT_EN defined:
//   per-transaction counter cleared on entering INIT_REQ/RD_REQ, counts through the REQ and WAIT states.
//   Reaching TIMEOUT_CYC -> ERR, error=1, drv_req=0.
//  Not defined: no counter logic; sequencer waits indefinitely for drv_ack/drv_done.
// TESTING
//  reset; start with init {6B:00,1C:08,1A:03}, driver model acks+done -> 3 writes in order, init_done=1, then read req reg=rd_reg.
//  rd_reg=3B, rd_len=14, model returns 3B..48 -> sample bytes 0..13 = 3B..48, sample_valid 1 clk; next drv_req POLL_PERIOD clk after done.
//  NACK on 2nd init write -> error=1, busy=0, no further drv_req; start again -> error=0, restart at entry 0.
//  rd_len=14, model sends 10 bytes then done -> error=1, sample unchanged; rd_len=0 -> drv_len=1; rd_len=15 -> drv_len=14.
//  start pulses during POLL_WAIT ignored; tick period exactly CLK_DIV clk; rst_n low mid-read -> all outputs 0 next edge.
//  with I2C_SEQ_TIMEOUT_EN, TIMEOUT_CYC=100, model never asserts done -> error=1 after 100 clk; without the macro -> still waiting.

Source files
------------

// File: rtl/i2c_seq_ctrl.sv
// I2C sensor sequencer: replays a register-write init table, then polls a burst read into a sample buffer.
// Optional per-transaction watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_seq_ctrl #(
    parameter int          CLK_DIV     = 6,
    parameter int          N_INIT      = 3,
    parameter int          MAX_RD      = 14,
    parameter int          POLL_PERIOD = 12000,
    parameter logic [6:0]  SLAVE_ADDR  = 7'h68,
    parameter int          TIMEOUT_CYC = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N_INIT*8-1:0]   init_addr,
    input  logic [N_INIT*8-1:0]   init_data,
    input  logic [7:0]            rd_reg,
    input  logic [3:0]            rd_len,
    output logic                  tick,
    output logic                  drv_req,
    input  logic                  drv_ack,
    output logic                  drv_rw,
    output logic [6:0]            drv_slave,
    output logic [7:0]            drv_reg,
    output logic [7:0]            drv_wdata,
    output logic [3:0]            drv_len,
    input  logic                  drv_rvalid,
    input  logic [7:0]            drv_rdata,
    input  logic                  drv_done,
    input  logic                  drv_nack,
    output logic [MAX_RD*8-1:0]   sample,
    output logic                  sample_valid,
    output logic                  init_done,
    output logic                  busy,
    output logic                  error
);

    localparam int               IDX_W    = (N_INIT > 1) ? $clog2(N_INIT) : 1;
    localparam int               TCK_W    = $clog2(CLK_DIV);
    localparam int               PW       = $clog2(POLL_PERIOD + 1);
    localparam logic [4:0]       MAX_L    = 5'(MAX_RD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INIT - 1);

    typedef enum logic [2:0] {
        IDLE, INIT_REQ, INIT_WAIT, RD_REQ, RD_WAIT, POLL_WAIT, ERR
    } state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [TCK_W-1:0]  tick_cnt_reg;
    logic [PW-1:0]     poll_cnt_reg;
    logic [4:0]        cnt_reg, cnt_inc, eff_len_reg, eff_len_new;
    logic              init_done_reg, sample_valid_reg;
    logic              start_ok, byte_take, rd_finish, init_last, enter_rd, timeout_hit;

    assign tick = (tick_cnt_reg == TCK_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick_cnt_reg <= '0;
        else
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
    end

    assign start_ok    = start && (state_reg == IDLE || state_reg == ERR);
    assign eff_len_new = (rd_len == 4'd0) ? 5'd1 :
                         ({1'b0, rd_len} > MAX_L) ? MAX_L : {1'b0, rd_len};
    // Bytes beyond the latched length are dropped; cnt_inc lets a byte arriving with drv_done count.
    assign byte_take   = (state_reg == RD_WAIT) && drv_rvalid && (cnt_reg < eff_len_reg);
    assign cnt_inc     = cnt_reg + 5'(byte_take);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        rd_finish  = 1'b0;
        init_last  = 1'b0;
        case (state_reg)
            IDLE, ERR: if (start) begin
                state_next = INIT_REQ;
                idx_next   = '0;
            end
            INIT_REQ: if (drv_ack) state_next = INIT_WAIT;
            INIT_WAIT: if (drv_done) begin
                if (drv_nack) begin
                    state_next = ERR;
                end else if (idx_reg == IDX_LAST) begin
                    state_next = RD_REQ;
                    init_last  = 1'b1;
                end else begin
                    state_next = INIT_REQ;
                    idx_next   = idx_reg + 1'b1;
                end
            end
            RD_REQ: if (drv_ack) state_next = RD_WAIT;
            RD_WAIT: if (drv_done) begin
                if (drv_nack || cnt_inc < eff_len_reg) begin
                    state_next = ERR;
                end else begin
                    state_next = POLL_WAIT;
                    rd_finish  = 1'b1;
                end
            end
            POLL_WAIT: if (poll_cnt_reg == PW'(POLL_PERIOD - 1)) state_next = RD_REQ;
            default: state_next = IDLE;
        endcase
        if (timeout_hit && state_next == state_reg)
            state_next = ERR;
    end

    assign enter_rd = (state_next == RD_REQ) && (state_reg != RD_REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            idx_reg          <= '0;
            poll_cnt_reg     <= '0;
            cnt_reg          <= '0;
            eff_len_reg      <= 5'd1;
            init_done_reg    <= 1'b0;
            sample_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            idx_reg          <= idx_next;
            poll_cnt_reg     <= (state_reg == POLL_WAIT) ? poll_cnt_reg + 1'b1 : '0;
            cnt_reg          <= (state_reg == RD_REQ) ? 5'd0 : cnt_inc;
            sample_valid_reg <= rd_finish;
            if (enter_rd)
                eff_len_reg <= eff_len_new;
            if (start_ok)
                init_done_reg <= 1'b0;
            else if (init_last)
                init_done_reg <= 1'b1;
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt_reg;
    logic          in_txn;

    assign in_txn      = (state_reg == INIT_REQ) || (state_reg == INIT_WAIT) ||
                         (state_reg == RD_REQ)   || (state_reg == RD_WAIT);
    assign timeout_hit = in_txn && (to_cnt_reg == TW'(TIMEOUT_CYC - 1));

    // Restart only on entering a request state, so one budget spans REQ and WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt_reg <= '0;
        else if (state_next != state_reg && (state_next == INIT_REQ || state_next == RD_REQ))
            to_cnt_reg <= '0;
        else if (in_txn)
            to_cnt_reg <= to_cnt_reg + 1'b1;
    end
`else
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < MAX_RD; gi++) begin : g_byte
            logic [7:0] shadow_reg, sample_reg;
            logic       take;

            assign take = byte_take && (cnt_reg == 5'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg <= 8'd0;
                    sample_reg <= 8'd0;
                end else begin
                    if (take)
                        shadow_reg <= drv_rdata;
                    if (rd_finish && 5'(gi) < eff_len_reg)
                        sample_reg <= take ? drv_rdata : shadow_reg;
                end
            end

            assign sample[gi*8 +: 8] = sample_reg;
        end
    endgenerate

    always_comb begin
        drv_req   = 1'b0;
        drv_rw    = 1'b0;
        drv_reg   = 8'd0;
        drv_wdata = 8'd0;
        drv_len   = 4'd0;
        case (state_reg)
            INIT_REQ: begin
                drv_req   = 1'b1;
                drv_reg   = init_addr[{idx_reg, 3'b000} +: 8];
                drv_wdata = init_data[{idx_reg, 3'b000} +: 8];
                drv_len   = 4'd1;
            end
            RD_REQ: begin
                drv_req = 1'b1;
                drv_rw  = 1'b1;
                drv_reg = rd_reg;
                drv_len = eff_len_reg[3:0];
            end
            default: ;
        endcase
    end

    assign drv_slave    = drv_req ? SLAVE_ADDR : 7'd0;
    assign sample_valid = sample_valid_reg;
    assign init_done    = init_done_reg;
    assign busy         = (state_reg != IDLE) && (state_reg != ERR);
    assign error        = (state_reg == ERR);

endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// Scoreboard bench for i2c_seq_ctrl: stimulus pushes expected driver requests, samples and errors;
// a negedge monitor pops and compares them as the DUT presents them.
module tb_i2c_seq_ctrl;

    localparam int CLK_DIV = 6;
    localparam int N_INIT  = 3;
    localparam int MAX_RD  = 14;
    localparam int POLL    = 20;
    localparam int TMO     = 100;
    localparam int EV_REQ  = 0;
    localparam int EV_SMP  = 1;
    localparam int EV_ERR  = 2;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [N_INIT*8-1:0] init_addr, init_data;
    logic [7:0] rd_reg = 8'h3B;
    logic [3:0] rd_len = 4'd14;
    logic tick, drv_req, drv_rw;
    logic drv_ack = 1'b0, drv_rvalid = 1'b0, drv_done = 1'b0, drv_nack = 1'b0;
    logic [7:0] drv_rdata = 8'h00;
    logic [6:0] drv_slave;
    logic [7:0] drv_reg, drv_wdata;
    logic [3:0] drv_len;
    logic [MAX_RD*8-1:0] sample;
    logic sample_valid, init_done, busy, error;

    i2c_seq_ctrl #(.CLK_DIV(CLK_DIV), .N_INIT(N_INIT), .MAX_RD(MAX_RD), .POLL_PERIOD(POLL),
                   .SLAVE_ADDR(7'h68), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .init_addr(init_addr), .init_data(init_data),
        .rd_reg(rd_reg), .rd_len(rd_len), .tick(tick), .drv_req(drv_req), .drv_ack(drv_ack),
        .drv_rw(drv_rw), .drv_slave(drv_slave), .drv_reg(drv_reg), .drv_wdata(drv_wdata),
        .drv_len(drv_len), .drv_rvalid(drv_rvalid), .drv_rdata(drv_rdata), .drv_done(drv_done),
        .drv_nack(drv_nack), .sample(sample), .sample_valid(sample_valid), .init_done(init_done),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  kind;
        logic                rw;
        logic [7:0]          rg;
        logic [7:0]          wd;
        logic [3:0]          ln;
        logic [MAX_RD*8-1:0] smp;
    } ev_t;

    ev_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_req(input logic rw, input logic [7:0] rg, input logic [7:0] wd, input logic [3:0] ln);
        ev_t e;
        e.kind = EV_REQ; e.rw = rw; e.rg = rg; e.wd = wd; e.ln = ln; e.smp = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_ev(input int kind, input logic [MAX_RD*8-1:0] smp);
        ev_t e;
        e.kind = kind; e.rw = 1'b0; e.rg = 8'h00; e.wd = 8'h00; e.ln = 4'd0; e.smp = smp;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual=%0d required=none", kind);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == EV_REQ && e.kind == EV_REQ) begin
                $display("req rw=%0d reg=%02h wdata=%02h len=%0d", drv_rw, drv_reg, drv_wdata, drv_len);
                check("req_rw", drv_rw, e.rw);
                check("req_reg", drv_reg, e.rg);
                check("req_len", drv_len, e.ln);
                check("req_slave", drv_slave, 7'h68);
                if (!e.rw) check("req_wdata", drv_wdata, e.wd);
            end else if (kind == EV_SMP && e.kind == EV_SMP) begin
                $display("sample %h", sample);
                check("sample", sample, e.smp);
            end else if (kind == EV_ERR) begin
                $display("error raised");
            end
        end
    endtask

    logic prev_req = 1'b0, prev_err = 1'b0;
    always @(negedge clk) begin
        if (drv_req && !prev_req) pop_check(EV_REQ);
        if (sample_valid)         pop_check(EV_SMP);
        if (error && !prev_err)   pop_check(EV_ERR);
        prev_req = drv_req;
        prev_err = error;
    end

    function automatic logic [MAX_RD*8-1:0] mk(input logic [7:0] base, input int n,
                                                input logic [MAX_RD*8-1:0] old);
        logic [MAX_RD*8-1:0] v;
        v = old;
        for (int k = 0; k < n; k++) v[k*8 +: 8] = base + 8'(k);
        return v;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 200 && !drv_req; i++) cyc(1);
        check("req_seen", drv_req, 1'b1);
    endtask

    task automatic ack();
        drv_ack = 1'b1; cyc(1); drv_ack = 1'b0;
    endtask

    task automatic done_pulse(input logic nack);
        drv_done = 1'b1; drv_nack = nack; cyc(1); drv_done = 1'b0; drv_nack = 1'b0;
    endtask

    task automatic serve_write(input logic nack);
        wait_req(); ack(); cyc(2); done_pulse(nack);
    endtask

    task automatic send_bytes(input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            drv_rvalid = 1'b1; drv_rdata = base + 8'(k); cyc(1);
        end
        drv_rvalid = 1'b0;
    endtask

    // overlap=1 delivers the final byte in the same cycle as drv_done.
    task automatic serve_read(input int n, input logic [7:0] base, input bit overlap);
        wait_req(); ack(); cyc(1);
        if (overlap) begin
            send_bytes(n - 1, base);
            drv_rvalid = 1'b1; drv_rdata = base + 8'(n - 1);
            done_pulse(1'b0);
            drv_rvalid = 1'b0;
        end else begin
            send_bytes(n, base);
            done_pulse(1'b0);
        end
    endtask

    task automatic push_init();
        push_req(1'b0, 8'h6B, 8'h00, 4'd1);
        push_req(1'b0, 8'h1C, 8'h08, 4'd1);
        push_req(1'b0, 8'h1A, 8'h03, 4'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MAX_RD*8-1:0] s1, s2, s3;
        int n;
        init_addr = {8'h1A, 8'h1C, 8'h6B};
        init_data = {8'h03, 8'h08, 8'h00};

        cyc(3);
        check("rst_req", drv_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_sample_valid", sample_valid, 1'b0);
        check("rst_sample", sample, '0);
        check("rst_tick", tick, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 20 && !tick; i++) cyc(1);
        for (int r = 0; r < 2; r++) begin
            n = 0;
            do begin cyc(1); n++; end while (!tick && n < 20);
            check("tick_period", n, CLK_DIV);
        end

        // Init replay then first burst read, no poll wait in between.
        s1 = mk(8'h3B, 14, '0);
        push_init();
        push_req(1'b1, 8'h3B, 8'h00, 4'd14);
        push_ev(EV_SMP, s1);
        pulse_start();
        check("start_latency", drv_req, 1'b1);
        serve_write(1'b0); serve_write(1'b0); serve_write(1'b0);
        check("init_done", init_done, 1'b1);
        serve_read(14, 8'h3B, 1'b0);
        check("sample_valid_pulse", sample_valid, 1'b1);
        push_req(1'b1, 8'h3B, 8'h00, 4'd14);
        n = 0;
        while (!drv_req && n < 200) begin
            cyc(1); n++;
            if (n == 1) check("sample_valid_one_clk", sample_valid, 1'b0);
        end
        check("poll_gap", n, POLL);

        // Final byte coincides with drv_done; start pulses during the poll wait are ignored.
        s2 = mk(8'hA0, 14, s1);
        push_ev(EV_SMP, s2);
        serve_read(14, 8'hA0, 1'b1);
        pulse_start(); cyc(2); pulse_start();
        check("poll_busy", busy, 1'b1);
        check("poll_init_done", init_done, 1'b1);
        check("poll_error", error, 1'b0);

        // Short read: 10 of 14 bytes.
        push_req(1'b1, 8'h3B, 8'h00, 4'd14);
        push_ev(EV_ERR, '0);
        serve_read(10, 8'h50, 1'b0);
        check("short_error", error, 1'b1);
        check("short_busy", busy, 1'b0);
        check("short_sample_kept", sample, s2);

        // NACK on second init write, then restart from entry 0.
        push_req(1'b0, 8'h6B, 8'h00, 4'd1);
        push_req(1'b0, 8'h1C, 8'h08, 4'd1);
        push_ev(EV_ERR, '0);
        pulse_start();
        serve_write(1'b0); serve_write(1'b1);
        check("nack_error", error, 1'b1);
        check("nack_busy", busy, 1'b0);
        cyc(20);
        check("nack_no_req", drv_req, 1'b0);

        rd_len = 4'd0;
        s3 = mk(8'hC5, 1, s2);
        push_init();
        push_req(1'b1, 8'h3B, 8'h00, 4'd1);
        push_ev(EV_SMP, s3);
        pulse_start();
        check("restart_error_clr", error, 1'b0);
        serve_write(1'b0); serve_write(1'b0); serve_write(1'b0);
        serve_read(1, 8'hC5, 1'b0);

        // rd_len above MAX_RD clamps; reset lands mid-read.
        rd_len = 4'd15;
        push_req(1'b1, 8'h3B, 8'h00, 4'd14);
        wait_req(); ack(); send_bytes(3, 8'h10);
        rst_n = 1'b0;
        #1;
        check("arst_req", drv_req, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_init_done", init_done, 1'b0);
        check("arst_sample", sample, '0);
        check("arst_len", drv_len, 4'd0);
        check("arst_tick", tick, 1'b0);
        cyc(2);
        rst_n = 1'b1;

        // Driver never completes the read.
        rd_len = 4'd14;
        push_init();
        push_req(1'b1, 8'h3B, 8'h00, 4'd14);
`ifdef I2C_SEQ_TIMEOUT_EN
        push_ev(EV_ERR, '0);
`endif
        pulse_start();
        serve_write(1'b0); serve_write(1'b0); serve_write(1'b0);
        wait_req(); ack(); cyc(89);
        check("tmo_early_error", error, 1'b0);
        cyc(15);
`ifdef I2C_SEQ_TIMEOUT_EN
        check("tmo_error", error, 1'b1);
        check("tmo_busy", busy, 1'b0);
`else
        check("wait_error", error, 1'b0);
        check("wait_busy", busy, 1'b1);
`endif
        cyc(5);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
